// File: rtl/isp_roi_pkg.sv
// Shared constants and helpers for the ROI window masker.
// Bound compares run at a fixed BW width, which supports coordinate widths up to 16 bits.
package isp_roi_pkg;

   localparam int unsigned ML_DEF     = 5;
   localparam int unsigned MR_DEF     = 12;
   localparam int unsigned MT_DEF     = 5;
   localparam int unsigned MB_DEF     = 5;
   localparam bit          VS_POL_DEF = 1'b1;

   // Width used for margin arithmetic; one bit wider than the largest coordinate.
   localparam int unsigned BW = 17;

   // LSB of window k inside a packed per-window bus of slice width w.
   function automatic int unsigned roi_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

   // lo+mlo <= pos <= hi-mhi, false when hi<mhi or the span is inverted.
   function automatic logic in_span(
      input logic [BW-1:0] pos,
      input logic [BW-1:0] lo,
      input logic [BW-1:0] hi,
      input logic [BW-1:0] mlo,
      input logic [BW-1:0] mhi
   );
      logic [BW-1:0] lb;
      logic [BW-1:0] ub;
      lb = lo + mlo;
      ub = hi - mhi;
      return (hi >= mhi) && (lb <= ub) && (pos >= lb) && (pos <= ub);
   endfunction

endpackage

// File: rtl/roi_window_cmp.sv
// Per-window containment compare and saturating foreground accumulator.
// The accumulator is handed to o_count and restarted on every frame start.
module roi_window_cmp
   import isp_roi_pkg::*;
#(
   parameter int unsigned HW = 12,
   parameter int unsigned CW = 24,
   parameter int unsigned ML = ML_DEF,
   parameter int unsigned MR = MR_DEF,
   parameter int unsigned MT = MT_DEF,
   parameter int unsigned MB = MB_DEF
) (
   input  logic          pixelclk,
   input  logic          reset_n,
   input  logic [HW-1:0] i_h,
   input  logic [HW-1:0] i_v,
   input  logic [HW-1:0] i_hl,
   input  logic [HW-1:0] i_hr,
   input  logic [HW-1:0] i_vl,
   input  logic [HW-1:0] i_vr,
   input  logic          i_en,
   input  logic          i_de,
   input  logic          i_binary,
   input  logic          i_fs,
   output logic          o_hit,
   output logic [CW-1:0] o_count
);

   logic          w_hin;
   logic          w_vin;
   logic          w_fg;
   logic [CW-1:0] r_acc;
   logic [CW-1:0] r_count;

   assign w_hin = in_span(BW'(i_h), BW'(i_hl), BW'(i_hr), BW'(ML), BW'(MR));
   assign w_vin = in_span(BW'(i_v), BW'(i_vl), BW'(i_vr), BW'(MT), BW'(MB));
   assign o_hit = i_en & i_de & w_hin & w_vin;
   assign w_fg  = o_hit & i_binary;

   // A foreground pixel in the frame-start cycle already belongs to the new frame.
   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc   <= '0;
         r_count <= '0;
      end else if (i_fs) begin
         r_count <= r_acc;
         r_acc   <= w_fg ? CW'(1) : '0;
      end else if (w_fg && (r_acc != '1)) begin
         r_acc <= r_acc + CW'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/roi_window_mask.sv
// Coordinate generator, multi-window binary masker and per-frame ROI statistics.
// Every pixel-rate output is registered once, so all of them share one cycle of latency.
module roi_window_mask
   import isp_roi_pkg::*;
#(
   parameter int unsigned DW     = 24,
   parameter int unsigned HW     = 12,
   parameter int unsigned NROI   = 4,
   parameter int unsigned CW     = 24,
   parameter int unsigned ML     = ML_DEF,
   parameter int unsigned MR     = MR_DEF,
   parameter int unsigned MT     = MT_DEF,
   parameter int unsigned MB     = MB_DEF,
   parameter bit          VS_POL = VS_POL_DEF
) (
   input  logic               pixelclk,
   input  logic               reset_n,
   input  logic [DW-1:0]      i_data,
   input  logic               i_binary,
   input  logic               i_hsync,
   input  logic               i_vsync,
   input  logic               i_de,
   input  logic [NROI*HW-1:0] roi_hl,
   input  logic [NROI*HW-1:0] roi_hr,
   input  logic [NROI*HW-1:0] roi_vl,
   input  logic [NROI*HW-1:0] roi_vr,
   input  logic [NROI-1:0]    roi_en,
   output logic [DW-1:0]      o_data,
   output logic               o_binary,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_de,
   output logic [HW-1:0]      hcount,
   output logic [HW-1:0]      vcount,
   output logic [NROI-1:0]    o_roi_hit,
   output logic [HW-1:0]      o_line_width,
   output logic [HW-1:0]      o_frame_lines,
   output logic [NROI*CW-1:0] o_roi_count,
   output logic               o_stats_valid
);

   logic [HW-1:0]      r_hcnt;
   logic [HW-1:0]      r_vcnt;
   logic               r_de_d;
   logic               r_vs_act_d;
   logic               r_seen_fs;
   logic [NROI*HW-1:0] r_sh_hl;
   logic [NROI*HW-1:0] r_sh_hr;
   logic [NROI*HW-1:0] r_sh_vl;
   logic [NROI*HW-1:0] r_sh_vr;
   logic [NROI-1:0]    r_sh_en;

   logic               w_vs_act;
   logic               w_fs;
   logic               w_line_end;
   logic [HW-1:0]      w_v;
   logic [NROI*HW-1:0] w_hl;
   logic [NROI*HW-1:0] w_hr;
   logic [NROI*HW-1:0] w_vl;
   logic [NROI*HW-1:0] w_vr;
   logic [NROI-1:0]    w_en;
   logic [NROI-1:0]    w_hit;

   assign w_vs_act   = (i_vsync == VS_POL);
   assign w_fs       = w_vs_act & ~r_vs_act_d;
   assign w_line_end = ~i_de & r_de_d;

   // A pixel coinciding with frame start sees row 0 and the freshly loaded windows.
   assign w_v  = w_fs ? '0     : r_vcnt;
   assign w_hl = w_fs ? roi_hl : r_sh_hl;
   assign w_hr = w_fs ? roi_hr : r_sh_hr;
   assign w_vl = w_fs ? roi_vl : r_sh_vl;
   assign w_vr = w_fs ? roi_vr : r_sh_vr;
   assign w_en = w_fs ? roi_en : r_sh_en;

   for (genvar k = 0; k < NROI; k++) begin : g_roi
      localparam int unsigned LH = roi_lsb(k, HW);
      localparam int unsigned LC = roi_lsb(k, CW);
      roi_window_cmp #(
         .HW (HW),
         .CW (CW),
         .ML (ML),
         .MR (MR),
         .MT (MT),
         .MB (MB)
      ) u_cmp (
         .pixelclk (pixelclk),
         .reset_n  (reset_n),
         .i_h      (r_hcnt),
         .i_v      (w_v),
         .i_hl     (w_hl[LH +: HW]),
         .i_hr     (w_hr[LH +: HW]),
         .i_vl     (w_vl[LH +: HW]),
         .i_vr     (w_vr[LH +: HW]),
         .i_en     (w_en[k]),
         .i_de     (i_de),
         .i_binary (i_binary),
         .i_fs     (w_fs),
         .o_hit    (w_hit[k]),
         .o_count  (o_roi_count[LC +: CW])
      );
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         r_hcnt     <= '0;
         r_vcnt     <= '0;
         r_de_d     <= 1'b0;
         r_vs_act_d <= 1'b0;
      end else begin
         r_de_d     <= i_de;
         r_vs_act_d <= w_vs_act;
         if (!i_de)
            r_hcnt <= '0;
         else if (r_hcnt != '1)
            r_hcnt <= r_hcnt + HW'(1);
         if (w_fs)
            r_vcnt <= '0;
         else if (w_line_end && (r_vcnt != '1))
            r_vcnt <= r_vcnt + HW'(1);
      end
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         r_sh_hl       <= '0;
         r_sh_hr       <= '0;
         r_sh_vl       <= '0;
         r_sh_vr       <= '0;
         r_sh_en       <= '0;
         r_seen_fs     <= 1'b0;
         o_frame_lines <= '0;
         o_line_width  <= '0;
         o_stats_valid <= 1'b0;
      end else begin
         // The first frame start after reset closes a partial frame, so no valid pulse.
         o_stats_valid <= w_fs & r_seen_fs;
         if (w_line_end)
            o_line_width <= r_hcnt;
         if (w_fs) begin
            r_sh_hl       <= roi_hl;
            r_sh_hr       <= roi_hr;
            r_sh_vl       <= roi_vl;
            r_sh_vr       <= roi_vr;
            r_sh_en       <= roi_en;
            r_seen_fs     <= 1'b1;
            o_frame_lines <= r_vcnt;
         end
      end
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         o_data    <= '0;
         o_binary  <= 1'b0;
         o_hsync   <= 1'b0;
         o_vsync   <= 1'b0;
         o_de      <= 1'b0;
         hcount    <= '0;
         vcount    <= '0;
         o_roi_hit <= '0;
      end else begin
         o_data    <= i_de ? i_data : '0;
         o_binary  <= i_de & i_binary & (|w_hit);
         o_hsync   <= i_hsync;
         o_vsync   <= i_vsync;
         o_de      <= i_de;
         hcount    <= i_de ? r_hcnt : '0;
         vcount    <= i_de ? w_v : '0;
         o_roi_hit <= w_hit;
      end
   end

endmodule

// File: tb/tb_roi_window_mask.sv
// Directed bench for roi_window_mask: reduced-size frames with hand-computed mask spans and counts.
module tb_roi_window_mask;

   logic        pixelclk = 1'b0;
   logic        reset_n  = 1'b0;
   logic [23:0] i_data   = '0;
   logic        i_binary = 1'b0;
   logic        i_hsync  = 1'b0;
   logic        i_vsync  = 1'b0;
   logic        i_de     = 1'b0;
   logic [47:0] roi_hl   = '0;
   logic [47:0] roi_hr   = '0;
   logic [47:0] roi_vl   = '0;
   logic [47:0] roi_vr   = '0;
   logic [3:0]  roi_en   = '0;

   logic [23:0] o_data;
   logic        o_binary;
   logic        o_hsync;
   logic        o_vsync;
   logic        o_de;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic [3:0]  o_roi_hit;
   logic [11:0] o_line_width;
   logic [11:0] o_frame_lines;
   logic [95:0] o_roi_count;
   logic        o_stats_valid;

   int checks   = 0;
   int failures = 0;

   int m_hl[4];
   int m_hr[4];
   int m_vl[4];
   int m_vr[4];
   bit m_en[4];

   int err_mask, err_hit, err_coord, err_blank;
   logic [11:0] last_lw;
   logic        sv_at_fs;
   logic [95:0] cnt_at_fs;
   logic [11:0] lines_at_fs;

   roi_window_mask dut (
      .pixelclk      (pixelclk),
      .reset_n       (reset_n),
      .i_data        (i_data),
      .i_binary      (i_binary),
      .i_hsync       (i_hsync),
      .i_vsync       (i_vsync),
      .i_de          (i_de),
      .roi_hl        (roi_hl),
      .roi_hr        (roi_hr),
      .roi_vl        (roi_vl),
      .roi_vr        (roi_vr),
      .roi_en        (roi_en),
      .o_data        (o_data),
      .o_binary      (o_binary),
      .o_hsync       (o_hsync),
      .o_vsync       (o_vsync),
      .o_de          (o_de),
      .hcount        (hcount),
      .vcount        (vcount),
      .o_roi_hit     (o_roi_hit),
      .o_line_width  (o_line_width),
      .o_frame_lines (o_frame_lines),
      .o_roi_count   (o_roi_count),
      .o_stats_valid (o_stats_valid)
   );

   always #5 pixelclk = ~pixelclk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Margins 5/12/5/5 applied to the window latched at the last frame start.
   function automatic bit exp_in(input int k, input int h, input int v);
      if (!m_en[k]) return 1'b0;
      if (m_hr[k] < 12 || m_vr[k] < 5) return 1'b0;
      return (h >= m_hl[k] + 5) && (h <= m_hr[k] - 12) &&
             (v >= m_vl[k] + 5) && (v <= m_vr[k] - 5);
   endfunction

   task automatic set_roi(input int k, input int hl, input int hr, input int vl, input int vr, input bit en);
      roi_hl[k*12 +: 12] = 12'(hl);
      roi_hr[k*12 +: 12] = 12'(hr);
      roi_vl[k*12 +: 12] = 12'(vl);
      roi_vr[k*12 +: 12] = 12'(vr);
      roi_en[k]          = en;
   endtask

   task automatic clr_model();
      for (int k = 0; k < 4; k++) m_en[k] = 1'b0;
   endtask

   task automatic clr_errs();
      err_mask = 0; err_hit = 0; err_coord = 0; err_blank = 0;
   endtask

   task automatic idle(input int n);
      i_de = 1'b0; i_binary = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge pixelclk); #1;
      end
   endtask

   // Two-cycle vsync pulse; statistics are captured right after the frame-start edge.
   task automatic vs_pulse();
      i_de = 1'b0; i_binary = 1'b0; i_hsync = 1'b0; i_vsync = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m_hl[k] = int'(roi_hl[k*12 +: 12]);
         m_hr[k] = int'(roi_hr[k*12 +: 12]);
         m_vl[k] = int'(roi_vl[k*12 +: 12]);
         m_vr[k] = int'(roi_vr[k*12 +: 12]);
         m_en[k] = roi_en[k];
      end
      @(posedge pixelclk); #1;
      sv_at_fs    = o_stats_valid;
      cnt_at_fs   = o_roi_count;
      lines_at_fs = o_frame_lines;
      @(posedge pixelclk); #1;
      chk("stats_valid_one_cycle", o_stats_valid, 0);
      idle(2);
   endtask

   task automatic line(input int w, input int v, input bit bin);
      logic [23:0] dat;
      logic [3:0]  eh;
      for (int h = 0; h < w; h++) begin
         dat = {12'(v), 12'(h)};
         i_de = 1'b1; i_binary = bin; i_hsync = 1'b0; i_data = dat;
         @(posedge pixelclk); #1;
         for (int k = 0; k < 4; k++) eh[k] = exp_in(k, h, v);
         if (o_roi_hit !== eh) err_hit++;
         if (o_binary !== (bin & (|eh))) err_mask++;
         if (hcount !== 12'(h) || vcount !== 12'(v) || o_data !== dat || o_de !== 1'b1) err_coord++;
      end
      i_de = 1'b0; i_binary = 1'b1; i_hsync = 1'b1; i_data = 24'hFFFFFF;
      @(posedge pixelclk); #1;
      if (o_data !== 0 || o_binary !== 0 || o_de !== 0 || o_roi_hit !== 0 || o_hsync !== 1) err_blank++;
      last_lw = o_line_width;
      i_hsync = 1'b0;
      @(posedge pixelclk); #1;
      if (o_data !== 0 || o_binary !== 0 || o_hsync !== 0) err_blank++;
   endtask

   task automatic frame(input int w, input int n, input bit bin);
      for (int v = 0; v < n; v++) line(w, v, bin);
   endtask

   task automatic chk_errs(input string tag);
      chk({tag, "_mask"},  err_mask,  0);
      chk({tag, "_hit"},   err_hit,   0);
      chk({tag, "_coord"}, err_coord, 0);
      chk({tag, "_blank"}, err_blank, 0);
   endtask

   initial begin
      clr_model();
      // Reset state
      repeat (3) @(posedge pixelclk);
      #1;
      chk("rst_data",  o_data, 0);
      chk("rst_flags", {o_binary, o_hsync, o_vsync, o_de, o_stats_valid, o_roi_hit}, 0);
      chk("rst_coord", {hcount, vcount, o_line_width, o_frame_lines}, 0);
      chk("rst_count", o_roi_count, 0);
      reset_n = 1'b1;
      idle(3);

      // Basic mask: ROI0 = (100,200,50,150) -> h 105..188, v 55..145
      set_roi(0, 100, 200, 50, 150, 1'b1);
      vs_pulse();
      chk("fs1_suppressed", sv_at_fs, 0);
      clr_errs();
      frame(201, 151, 1'b1);
      chk_errs("basic");
      chk("basic_line_width", last_lw, 201);
      roi_en = 4'b0000;
      vs_pulse();
      chk("fs2_valid", sv_at_fs, 1);
      chk("basic_cnt0", cnt_at_fs[23:0], 7644);
      chk("basic_cnt_rest", cnt_at_fs[95:24], 0);
      chk("basic_frame_lines", lines_at_fs, 151);

      // Generic resolution with every window disabled
      clr_errs();
      frame(64, 20, 1'b1);
      chk_errs("generic");
      chk("generic_line_width", last_lw, 64);
      set_roi(0, 2, 30, 0, 12, 1'b1);
      set_roi(1, 2, 30, 0, 12, 1'b1);
      vs_pulse();
      chk("fs3_valid", sv_at_fs, 1);
      chk("generic_frame_lines", lines_at_fs, 20);
      chk("generic_counts", cnt_at_fs, 0);

      // Overlap: h 7..18, v 5..7 in both windows; ROI0 left bound moves mid-frame
      clr_errs();
      frame(40, 6, 1'b1);
      set_roi(0, 10, 30, 0, 12, 1'b1);
      for (int v = 6; v < 16; v++) line(40, v, 1'b1);
      chk_errs("overlap");
      set_roi(2, 0, 10, 0, 15, 1'b1);
      set_roi(3, 20, 30, 0, 15, 1'b1);
      vs_pulse();
      chk("fs4_valid", sv_at_fs, 1);
      chk("overlap_cnt0", cnt_at_fs[23:0], 36);
      chk("overlap_cnt1", cnt_at_fs[47:24], 36);
      chk("overlap_frame_lines", lines_at_fs, 16);

      // New ROI0 bound (h 15..18) plus two degenerate windows
      clr_errs();
      frame(40, 16, 1'b1);
      chk_errs("shadow");
      vs_pulse();
      chk("fs5_valid", sv_at_fs, 1);
      chk("shadow_cnt0", cnt_at_fs[23:0], 12);
      chk("shadow_cnt1", cnt_at_fs[47:24], 36);
      chk("degen_cnt2", cnt_at_fs[71:48], 0);
      chk("degen_cnt3", cnt_at_fs[95:72], 0);

      // Reset asserted in the middle of a line
      for (int h = 0; h < 8; h++) begin
         i_de = 1'b1; i_binary = 1'b1; i_data = 24'h00ABCD;
         @(posedge pixelclk); #1;
      end
      #2 reset_n = 1'b0;
      @(posedge pixelclk); #1;
      chk("midrst_flags", {o_binary, o_de, o_stats_valid, o_roi_hit}, 0);
      chk("midrst_data_coord", {o_data, hcount, vcount, o_line_width, o_frame_lines}, 0);
      chk("midrst_count", o_roi_count, 0);
      i_de = 1'b0; i_binary = 1'b0;
      #3 reset_n = 1'b1;
      clr_model();
      idle(2);
      clr_errs();
      line(40, 0, 1'b1);
      chk_errs("postrst");
      vs_pulse();
      chk("fs6_suppressed", sv_at_fs, 0);
      frame(40, 16, 1'b1);
      vs_pulse();
      chk("fs7_valid", sv_at_fs, 1);
      chk("postrst_cnt0", cnt_at_fs[23:0], 12);
      chk("postrst_cnt1", cnt_at_fs[47:24], 36);
      chk("postrst_frame_lines", lines_at_fs, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/roi_window_mask.md
Name: roi_window_mask

Overview:
- Parametrised successor to the single-window HV counter/masker in the ISP chain; sits between binarisation and blob/feature extraction.
- Generates pixel coordinates from DE/VSYNC alone, with no fixed 1024x768 assumption. Measures line width and frame height.
- Masks the binary stream against NROI independently enabled rectangular windows with configurable margins. Accumulates per-window foreground pixel counts for each frame.
- All outputs are registered and mutually aligned.

Parameters:
- DW, 24, width of i_data/o_data.
- HW, 12, coordinate width for hcount, vcount and ROI bounds.
- NROI, 4, number of ROI windows (1..8).
- CW, 24, width of each per-ROI foreground counter.
- ML / MR / MT / MB, 5 / 12 / 5 / 5, left/right/top/bottom margins in pixels.
- VS_POL, 1, active level of i_vsync.

Ports:
- pixelclk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- i_data  in  DW  pixel data
- i_binary  in  1  binarised pixel
- i_hsync / i_vsync / i_de  in  1 each  video timing
- roi_hl, roi_hr  in  NROI*HW  per-window left/right column bounds (packed, window k at [k*HW +: HW])
- roi_vl, roi_vr  in  NROI*HW  per-window top/bottom row bounds
- roi_en  in  NROI  per-window enable
- o_data  out  DW  delayed data, 0 when o_de=0
- o_binary  out  1  masked binary, 0 when o_de=0
- o_hsync / o_vsync / o_de  out  1 each  timing delayed 1 cycle
- hcount, vcount  out  HW each  coordinate of the pixel currently on o_data
- o_roi_hit  out  NROI  per-window containment flags for the current pixel
- o_line_width  out  HW  pixels in the last completed DE line
- o_frame_lines  out  HW  lines in the last completed frame
- o_roi_count  out  NROI*CW  per-window foreground counts of the last frame
- o_stats_valid  out  1  one-cycle pulse when o_roi_count / o_frame_lines update

Behaviour:
- **Reset:** all outputs, counters, shadow registers and accumulators go to 0. Shadow roi_en is 0, so all windows are disabled until the first frame start.
- **Latency:** exactly 1 cycle, input to output, for every pixel-rate output, including o_binary.
- **Horizontal counter:**
  - Internal h_cnt; the pixel with i_de=1 takes coordinate h_cnt.
  - h_cnt increments while i_de=1 and clears to 0 whenever i_de=0.
  - h_cnt saturates at 2^HW-1; it never wraps.
- **Line end:** on the DE falling edge (i_de=0, previous i_de=1), o_line_width <= h_cnt and v_cnt increments, saturating at 2^HW-1.
- **Frame start:** defined as i_vsync transitioning to VS_POL. In that cycle:
  - o_frame_lines <= v_cnt, and v_cnt <= 0.
  - Shadow ROI registers load from roi_*, so mid-frame changes never tear a frame.
  - Accumulators transfer to o_roi_count and then clear.
  - o_stats_valid pulses, except on the first frame start after reset, which is suppressed (partial frame).
- **Same-cycle frame start and DE:** if frame start coincides with i_de=1, that pixel is evaluated with vcount=0 and the new shadow ROIs.
- **Containment:** window k contains the pixel iff shadow_en[k] and both of the following hold:
  - hl+ML <= h <= hr-MR
  - vl+MT <= v <= vr-MB
- **Containment arithmetic:**
  - Compute in HW+1 bits.
  - If hr<MR or vr<MB, or the lower bound exceeds the upper bound, the window is empty: never hit, never counted.
- **Outputs from containment:**
  - o_roi_hit[k] = containment result, registered with the pixel.
  - o_binary = i_binary AND (OR over o_roi_hit), registered.
- **Accumulator k:** increments when i_de=1, i_binary=1 and window k contains the pixel. It saturates at 2^CW-1. Overlapping windows each count the same pixel.
- **Reset mid-frame:** everything clears immediately, and counting resumes at the next frame start.

Decomposition:
- **Shared package isp_roi_pkg:**
  - margin default constants.
  - VS_POL default.
  - helper function for the empty-window-safe bound compare.
  - localparam for the packed-slice index.
- **Sub-module roi_window_cmp:** one per window via generate. Pure per-window compare plus accumulator with saturation. The top level holds the counters, edge detection, shadows and the output pipeline.

Test Plan:
- **Basic mask:** 1024x768 timing, i_binary=1, ROI0=(hl 100, hr 200, vl 50, vr 150) enabled, others off.
  - o_binary=1 exactly for h 105..188 and v 55..145.
  - o_roi_count[0] = 84*91 = 7644 with o_stats_valid at the next frame start.
- **Generic resolution:** 640x480 DE, no ROIs enabled.
  - o_line_width=640, o_frame_lines=480.
  - hcount 0..639 aligned with o_data, o_binary=0 throughout.
- **Overlap:** ROI0 and ROI1 identical, both enabled.
  - o_roi_hit=2'b11 inside the window, o_binary unchanged.
  - Both counts equal.
- **Shadowing:** change roi_hl mid-frame.
  - The current frame mask is unchanged.
  - The new bound takes effect from v=0 of the next frame.
- **Degenerate window:** hr=10 (less than MR=12), and separately hl+ML > hr-MR.
  - Zero hits and count 0.
- **Reset:** assert reset_n low mid-line.
  - All outputs are 0 on the next edge.
  - The first post-reset frame start gives no o_stats_valid; the second frame start gives valid counts.
